// File: rtl/seq_multiplier_if.sv
// Operand/result bundle between a requester and the sequential multiplier.
// Latency: none (wires only).
// Backpressure: the requester must hold start until busy is low; start is not queued.
interface seq_multiplier_if #(
  parameter int WIDTH = 4
);
  logic               ena;
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               signed_mode;
  logic               acc_mode;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (
    output ena, start, a, b, signed_mode, acc_mode,
    input  busy, done, product
  );

  modport slave (
    input  ena, start, a, b, signed_mode, acc_mode,
    output busy, done, product
  );
endinterface

// File: rtl/seq_multiplier.sv
// Shift-and-add multiplier, unsigned or two's-complement, optional accumulate.
// Latency: WIDTH+1 enabled cycles from accept to done; one op per WIDTH+2 cycles.
// Backpressure: start only sampled in IDLE; ena=0 freezes all state and outputs.
module seq_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  seq_multiplier_if.slave  bus
);
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q,   state_d;
  logic [CW-1:0]    cnt_q,     cnt_d;
  logic [PW-1:0]    mcand_q,   mcand_d;
  logic [WIDTH-1:0] mplr_q,    mplr_d;
  logic [PW-1:0]    sum_q,     sum_d;
  logic             neg_q,     neg_d;
  logic             acc_q,     acc_d;
  logic [PW-1:0]    product_q, product_d;

  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [PW-1:0]    sum_step;
  logic [PW-1:0]    res;

  // Next-state, datapath step and result commit, all gated by ena
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    mplr_d    = mplr_q;
    sum_d     = sum_q;
    neg_d     = neg_q;
    acc_d     = acc_q;
    product_d = product_q;

    // Magnitudes; the most negative value maps to 2^(WIDTH-1), still fits unsigned
    mag_a = (bus.signed_mode && bus.a[WIDTH-1]) ? (~bus.a + 1'b1) : bus.a;
    mag_b = (bus.signed_mode && bus.b[WIDTH-1]) ? (~bus.b + 1'b1) : bus.b;

    // Partial sum including this step's add, so the last step can commit directly
    sum_step = sum_q + (mplr_q[0] ? mcand_q : '0);
    res      = neg_q ? (~sum_step + 1'b1) : sum_step;

    if (bus.ena) begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_d = S_RUN;
            cnt_d   = '0;
            mcand_d = {{WIDTH{1'b0}}, mag_a};
            mplr_d  = mag_b;
            sum_d   = '0;
            neg_d   = bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            acc_d   = bus.acc_mode;
          end
        end
        S_RUN: begin
          sum_d   = sum_step;
          mcand_d = mcand_q << 1;
          mplr_d  = mplr_q >> 1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d   = S_DONE;
            product_d = acc_q ? (product_q + res) : res;
          end
        end
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State registers; reset aborts any operation and clears the result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      mcand_q   <= '0;
      mplr_q    <= '0;
      sum_q     <= '0;
      neg_q     <= 1'b0;
      acc_q     <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      mplr_q    <= mplr_d;
      sum_q     <= sum_d;
      neg_q     <= neg_d;
      acc_q     <= acc_d;
      product_q <= product_d;
    end
  end

  assign bus.busy    = (state_q == S_RUN) || (state_q == S_DONE);
  assign bus.done    = (state_q == S_DONE);
  assign bus.product = product_q;
endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier at WIDTH=4 and WIDTH=8.
// Latency: checks done at the (WIDTH+1)th cycle after accept, plus stalls.
// Backpressure: exercises ena stalls, held start and ignored start.
module tb_seq_multiplier;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [7:0]  model4;
  logic [15:0] model8;

  seq_multiplier_if #(.WIDTH(4)) if4 ();
  seq_multiplier_if #(.WIDTH(8)) if8 ();

  seq_multiplier #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  seq_multiplier #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: signed/unsigned integer product, truncated to 2*WIDTH bits
  function automatic logic [7:0] ref4(input logic [3:0] a, input logic [3:0] b,
                                      input logic sm, input logic am, input logic [7:0] prev);
    int sa, sb, p;
    sa = sm ? int'($signed(a)) : int'(a);
    sb = sm ? int'($signed(b)) : int'(b);
    p  = sa * sb;
    return am ? (prev + p[7:0]) : p[7:0];
  endfunction

  function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b,
                                       input logic sm, input logic am, input logic [15:0] prev);
    int sa, sb, p;
    sa = sm ? int'($signed(a)) : int'(a);
    sb = sm ? int'($signed(b)) : int'(b);
    p  = sa * sb;
    return am ? (prev + p[15:0]) : p[15:0];
  endfunction

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic sm, input logic am,
                     output int lat, output logic [7:0] got);
    int n;
    n = 0;
    while (if4.busy && n < 40) begin @(posedge clk); #1; n++; end
    if4.a = a; if4.b = b; if4.signed_mode = sm; if4.acc_mode = am; if4.start = 1'b1;
    @(posedge clk); #1;
    if4.start = 1'b0;
    if4.a = 4'($urandom); if4.b = 4'($urandom);
    if4.signed_mode = 1'($urandom); if4.acc_mode = 1'($urandom);
    lat = 1;
    while (!if4.done && lat < 40) begin @(posedge clk); #1; lat++; end
    got = if4.product;
    model4 = ref4(a, b, sm, am, model4);
    checks++;
    if (got !== model4) begin
      errors++;
      $display("FAIL op4_product a=%h b=%h sm=%0b am=%0b got=%h exp=%h", a, b, sm, am, got, model4);
    end
    @(posedge clk); #1;
    checks++;
    if (if4.done !== 1'b0 || if4.busy !== 1'b0) begin
      errors++;
      $display("FAIL op4_done_pulse done=%0b busy=%0b exp done=0 busy=0", if4.done, if4.busy);
    end
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic sm, input logic am,
                     output int lat, output logic [15:0] got);
    int n;
    n = 0;
    while (if8.busy && n < 40) begin @(posedge clk); #1; n++; end
    if8.a = a; if8.b = b; if8.signed_mode = sm; if8.acc_mode = am; if8.start = 1'b1;
    @(posedge clk); #1;
    if8.start = 1'b0;
    if8.a = 8'($urandom); if8.b = 8'($urandom);
    lat = 1;
    while (!if8.done && lat < 40) begin @(posedge clk); #1; lat++; end
    got = if8.product;
    model8 = ref8(a, b, sm, am, model8);
    checks++;
    if (got !== model8) begin
      errors++;
      $display("FAIL op8_product a=%h b=%h sm=%0b am=%0b got=%h exp=%h", a, b, sm, am, got, model8);
    end
    @(posedge clk); #1;
  endtask

  task automatic chk_lat(input string name, input int lat, input int exp);
    checks++;
    if (lat != exp) begin
      errors++;
      $display("FAIL %s latency got=%0d exp=%0d", name, lat, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (if4.busy !== 1'b0 || if4.done !== 1'b0 || if4.product !== 8'h00 ||
        if8.busy !== 1'b0 || if8.done !== 1'b0 || if8.product !== 16'h0000) begin
      errors++;
      $display("FAIL reset_state busy=%0b done=%0b p4=%h p8=%h exp all zero",
               if4.busy, if4.done, if4.product, if8.product);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model4 = '0; model8 = '0;
  endtask

  task automatic test_unsigned();
    int lat, busy_cnt;
    logic [7:0] got;
    int n;
    while (if4.busy) begin @(posedge clk); #1; end
    if4.a = 4'hF; if4.b = 4'hF; if4.signed_mode = 1'b0; if4.acc_mode = 1'b0; if4.start = 1'b1;
    @(posedge clk); #1;
    if4.start = 1'b0;
    lat = 1; busy_cnt = 0;
    for (n = 0; n < 40 && !if4.done; n++) begin
      if (if4.busy) busy_cnt++;
      @(posedge clk); #1; lat++;
    end
    if (if4.busy) busy_cnt++;
    chk_lat("unsigned_15x15", lat, 5);
    chk8("unsigned_15x15_product", {8'h00, if4.product}, 16'h00E1);
    checks++;
    if (busy_cnt != 5) begin
      errors++;
      $display("FAIL unsigned_busy_cycles got=%0d exp=5", busy_cnt);
    end
    @(posedge clk); #1;
    checks++;
    if (if4.busy !== 1'b0) begin
      errors++;
      $display("FAIL unsigned_busy_fall got=%0b exp=0", if4.busy);
    end
    model4 = 8'hE1;
    op4(4'h9, 4'hB, 1'b0, 1'b0, lat, got);
    chk8("unsigned_9x11", {8'h00, got}, 16'h0063);
  endtask

  task automatic test_signed();
    int lat;
    logic [7:0] got;
    op4(4'h8, 4'h8, 1'b1, 1'b0, lat, got);
    chk8("signed_m8xm8", {8'h00, got}, 16'h0040);
    op4(4'h8, 4'h7, 1'b1, 1'b0, lat, got);
    chk8("signed_m8x7", {8'h00, got}, 16'h00C8);
    op4(4'h7, 4'hF, 1'b1, 1'b0, lat, got);
    chk8("signed_7xm1", {8'h00, got}, 16'h00F9);
    chk_lat("signed_lat", lat, 5);
  endtask

  task automatic test_accumulate();
    int lat;
    logic [7:0] got;
    op4(4'h3, 4'h5, 1'b0, 1'b0, lat, got);
    chk8("acc_first", {8'h00, got}, 16'h000F);
    op4(4'h2, 4'h2, 1'b0, 1'b1, lat, got);
    chk8("acc_add", {8'h00, got}, 16'h0013);
    op4(4'hF, 4'hF, 1'b0, 1'b1, lat, got);
    chk8("acc_wrap", {8'h00, got}, 16'h00F4);
  endtask

  task automatic test_back_to_back();
    int times[$];
    logic prev_done;
    while (if4.busy) begin @(posedge clk); #1; end
    if4.a = 4'h1; if4.b = 4'h1; if4.signed_mode = 1'b0; if4.acc_mode = 1'b0; if4.start = 1'b1;
    prev_done = 1'b0;
    for (int t = 0; t < 30; t++) begin
      @(posedge clk); #1;
      if (if4.done) times.push_back(t);
      checks++;
      if (if4.done && prev_done) begin
        errors++;
        $display("FAIL b2b_done_width at t=%0d got two-cycle pulse exp one", t);
      end
      prev_done = if4.done;
    end
    if4.start = 1'b0;
    checks++;
    if (times.size() < 3) begin
      errors++;
      $display("FAIL b2b_count got=%0d exp>=3", times.size());
    end else begin
      for (int i = 1; i < times.size(); i++)
        chk_lat("b2b_period", times[i] - times[i-1], 6);
    end
    chk8("b2b_product", {8'h00, if4.product}, 16'h0001);
    while (if4.busy) begin @(posedge clk); #1; end
    model4 = 8'h01;
  endtask

  task automatic test_ignore_start();
    int n;
    while (if4.busy) begin @(posedge clk); #1; end
    if4.a = 4'h3; if4.b = 4'h3; if4.signed_mode = 1'b0; if4.acc_mode = 1'b0; if4.start = 1'b1;
    @(posedge clk); #1;
    if4.start = 1'b0;
    n = 1;
    while (!if4.done && n < 40) begin
      if (n == 2) begin if4.start = 1'b1; if4.a = 4'hF; if4.b = 4'hF; end
      if (n == 3) if4.start = 1'b0;
      @(posedge clk); #1; n++;
    end
    if4.start = 1'b1; if4.a = 4'hE; if4.b = 4'hE;
    @(posedge clk); #1;
    if4.start = 1'b0;
    chk8("ignore_start_product", {8'h00, if4.product}, 16'h0009);
    checks++;
    if (if4.busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_start_busy got=%0b exp=0", if4.busy);
    end
    model4 = 8'h09;
  endtask

  task automatic test_reset_enable();
    int lat;
    logic [7:0] got;
    op4(4'h3, 4'h5, 1'b0, 1'b0, lat, got);
    op4(4'h2, 4'h2, 1'b0, 1'b1, lat, got);
    chk8("pre_reset_product", {8'h00, got}, 16'h0013);
    if4.a = 4'h7; if4.b = 4'h7; if4.acc_mode = 1'b1; if4.start = 1'b1;
    @(posedge clk); #1;
    if4.start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    checks++;
    if (if4.product !== 8'h00 || if4.busy !== 1'b0 || if4.done !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset product=%h busy=%0b done=%0b exp 00/0/0",
               if4.product, if4.busy, if4.done);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model4 = '0; model8 = '0;
    // Stall 3 cycles mid-run
    if4.a = 4'h5; if4.b = 4'h6; if4.signed_mode = 1'b0; if4.acc_mode = 1'b0; if4.start = 1'b1;
    @(posedge clk); #1;
    if4.start = 1'b0;
    lat = 1;
    while (!if4.done && lat < 40) begin
      if (lat == 2) if4.ena = 1'b0;
      if (lat == 5) if4.ena = 1'b1;
      @(posedge clk); #1; lat++;
    end
    chk_lat("stall_latency", lat, 8);
    chk8("stall_product", {8'h00, if4.product}, 16'h001E);
    if4.ena = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if (if4.done !== 1'b1 || if4.product !== 8'h1E) begin
      errors++;
      $display("FAIL stall_done_hold done=%0b product=%h exp 1/1e", if4.done, if4.product);
    end
    if4.ena = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (if4.done !== 1'b0) begin
      errors++;
      $display("FAIL stall_done_release done=%0b exp 0", if4.done);
    end
    model4 = 8'h1E;
  endtask

  task automatic test_random4();
    int lat;
    logic [7:0] got;
    for (int i = 0; i < 200; i++) begin
      op4(4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), lat, got);
      chk_lat("rand4", lat, 5);
    end
  endtask

  task automatic test_width8();
    int lat;
    logic [15:0] got;
    op8(8'hFF, 8'hFF, 1'b0, 1'b0, lat, got);
    chk8("w8_255x255", got, 16'hFE01);
    chk_lat("w8_255x255", lat, 9);
    op8(8'h80, 8'h80, 1'b1, 1'b0, lat, got);
    chk8("w8_m128xm128", got, 16'h4000);
    for (int i = 0; i < 1000; i++) begin
      op8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), lat, got);
      chk_lat("rand8", lat, 9);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    model4 = '0; model8 = '0;
    rst_n = 1'b0;
    if4.ena = 1'b1; if4.start = 1'b0; if4.a = '0; if4.b = '0;
    if4.signed_mode = 1'b0; if4.acc_mode = 1'b0;
    if8.ena = 1'b1; if8.start = 1'b0; if8.a = '0; if8.b = '0;
    if8.signed_mode = 1'b0; if8.acc_mode = 1'b0;
    test_reset();
    @(posedge clk); #1;
    test_unsigned();
    test_signed();
    test_accumulate();
    test_back_to_back();
    test_ignore_start();
    test_reset_enable();
    test_random4();
    test_width8();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
